// File: rtl/apb_master_ctrl.sv
// APB master: pops commands from a FWFT FIFO and runs one SETUP/ACCESS transfer per command.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_master_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_data,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              cmd_pop,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic [DATA_W-1:0] rdata_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..255");
  end

  logic [1:0]        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_access;
  logic              timeout_hit;

  assign in_access = (state_q == ACCESS);
  assign cmd_pop   = (state_q == IDLE) && cmd_valid && !reset;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  logic [7:0] tcnt_q, tcnt_d;

  // Counter restarts while in SETUP so it reads 0 on the first ACCESS cycle.
  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == SETUP) begin
      tcnt_d = '0;
    end else if (in_access && !pready) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  assign timeout_hit = in_access && !pready && (tcnt_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pwrite_d  = pwrite_q;
    is_read_d = is_read_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_pop) begin
          paddr_d   = cmd_addr;
          pwdata_d  = cmd_wdata;
          pwrite_d  = (cmd_data == CMD_WRITE);
          is_read_d = (cmd_data == CMD_READ);
          // NOP and reserved codes are consumed without starting a transfer.
          if (cmd_data == CMD_READ || cmd_data == CMD_WRITE) begin
            state_d = SETUP;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = pslverr;
          if (is_read_q && !pslverr) begin
            rdata_d = prdata;
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    psel_d    = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      is_read_q <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      is_read_q <= is_read_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign rdata_o = rdata_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16, maximum ACCESS cycles without pready (range 1..255).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port cmd_valid, input, 1, command FIFO not empty (first-word-fall-through).
REQ-008 The block SHALL have port cmd_data, input, 2, command code: 00 NOP, 01 READ, 10 WRITE, 11 reserved.
REQ-009 The block SHALL have port cmd_addr, input, ADDR_W, transfer address, valid with cmd_valid.
REQ-010 The block SHALL have port cmd_wdata, input, DATA_W, write data, valid with cmd_valid.
REQ-011 The block SHALL have port cmd_pop, output, 1, combinational FIFO pop.
REQ-012 The block SHALL have APB ports psel, penable, pwrite (outputs, 1 each), paddr (output, ADDR_W), pwdata (output, DATA_W), prdata (input, DATA_W), pready and pslverr (inputs, 1 each).
REQ-013 The block SHALL have ports rdata_o (output, DATA_W, read result), done_o (output, 1, one-cycle completion pulse), err_o (output, 1, one-cycle error pulse) and busy_o (output, 1, state != IDLE).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS.
REQ-015 cmd_pop SHALL equal (state==IDLE) && cmd_valid && !reset.
REQ-016 On a pop edge the block SHALL latch cmd_data, cmd_addr and cmd_wdata.
REQ-017 On a pop edge the next state SHALL be SETUP for READ/WRITE; for NOP and 11 the state SHALL remain IDLE with the command discarded and no APB activity.
REQ-018 In SETUP, psel=1 and penable=0 SHALL hold, and the next state SHALL be ACCESS unconditionally.
REQ-019 In ACCESS, psel=1 and penable=1 SHALL hold.
REQ-020 In SETUP and ACCESS, paddr, pwrite (1 for WRITE) and pwdata SHALL be held stable from the latched values.
REQ-021 In ACCESS with pready=1, the next state SHALL be IDLE, and the next cycle SHALL assert done_o=1 for one cycle.
REQ-022 In ACCESS with pready=1, err_o SHALL equal pslverr in the next cycle.
REQ-023 A READ completing in ACCESS with pready=1 SHALL load rdata_o with prdata; rdata_o SHALL be unchanged on writes and errors.
REQ-024 In ACCESS with pready=0, the state SHALL remain ACCESS (wait state).
REQ-025 psel, penable, done_o and err_o SHALL be registered, with no combinational path from APB inputs.
REQ-026 Latency SHALL be: pop at edge N; SETUP in cycle N+1; ACCESS in N+2; with zero wait states, done_o in N+3.
REQ-027 A new pop SHALL be allowed in N+3, giving a 3-cycle back-to-back throughput.
REQ-028 When IDLE and cmd_valid=0, psel=0, penable=0 and cmd_pop=0 SHALL hold.
REQ-029 pready and pslverr SHALL be ignored outside ACCESS.

Reset
REQ-030 reset SHALL take priority over all other inputs on any edge, including mid-SETUP or mid-ACCESS, and force state IDLE.
REQ-031 After reset, psel, penable, pwrite, done_o, err_o and busy_o SHALL be 0, and paddr, pwdata and rdata_o SHALL be all zeros.
REQ-032 After reset, the timeout counter SHALL be 0 and any in-flight transfer SHALL be abandoned without done_o.

Configuration
REQ-033 Macro APB_TIMEOUT_EN defined: an 8-bit counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-034 With APB_TIMEOUT_EN defined and the counter reaching TIMEOUT_CYC-1 while pready=0, the block SHALL abort to IDLE and pulse done_o=1 and err_o=1 next cycle, with rdata_o unchanged.
REQ-035 Macro APB_TIMEOUT_EN undefined: there SHALL be no counter, and ACCESS SHALL wait indefinitely for pready.

Verification
REQ-036 Reset, then WRITE addr 0x10 data 0xDEADBEEF with pready=1 -> psel at N+1, penable at N+2, pwrite=1, done_o at N+3, err_o=0.
REQ-037 READ addr 0x24, pready low 3 ACCESS cycles, prdata 0x12345678 -> ACCESS lasts 4 cycles, paddr stable, rdata_o=0x12345678 with done_o.
REQ-038 NOP then WRITE in FIFO -> two pops on consecutive edges, psel stays 0 for the NOP, the WRITE proceeds normally.
REQ-039 WRITE with pslverr=1 at pready -> done_o=1, err_o=1 same cycle, rdata_o unchanged.
REQ-040 APB_TIMEOUT_EN, TIMEOUT_CYC=4, pready held 0 -> abort after 4 ACCESS cycles, done_o=1, err_o=1, IDLE; without the macro, psel stays 1 for 50+ cycles.
REQ-041 Assert reset during ACCESS -> next cycle psel=0, penable=0, busy_o=0, no done_o.
